// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave control sequencer.
package microwave_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COOK  = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam int unsigned MAX_DIGITS       = 3;
   localparam int unsigned TICK_DIV_DEFAULT = 100;

   // Returns the index of the single set bit, or 4'hF for zero/multi-hot input.
   function automatic logic [3:0] onehot_to_digit(input logic [9:0] oh);
      logic [3:0] d;
      d = 4'hF;
      if ($countones(oh) == 1) begin
         for (int k = 0; k < 10; k++) begin
            if (oh[k]) d = 4'(k);
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/mw_tick_gen.sv
// One-second prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the last one.
module mw_tick_gen #(
   parameter int unsigned TICK_DIV = 100
) (
   input  logic clock,
   input  logic resetn,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick = en && (cnt_q == LAST);

   // With en low the count is held, which keeps a paused partial second.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/microwave_ctrl.sv
// Front-panel sequencer: key/button edge detect, IDLE/COOK/PAUSE control, 1 Hz enable.
module microwave_ctrl
   import microwave_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [9:0] keypad,
   input  logic       startn,
   input  logic       stopn,
   input  logic       clearn,
   input  logic       door_closed,
   input  logic       timer_zero,
   output logic       shift_en,
   output logic [3:0] shift_digit,
   output logic       count_en,
   output logic       timer_clr,
   output logic       mag_on,
   output logic       done
);

   localparam int unsigned DW = $clog2(MAX_DIGITS + 1);
   localparam logic [DW-1:0] DIGIT_MAX = DW'(MAX_DIGITS);

   state_t        state_q;
   logic [2:0]    btn_q, btn_prev_q;  // {start, stop, clear}, 1 = released
   logic [9:0]    key_q, key_prev_q;
   logic [DW-1:0] digit_cnt_q;

   logic start_evt, stop_evt, clear_evt, key_evt;
   logic start_ok;
   logic pre_clr, pre_en, tick;

   assign start_evt = btn_prev_q[2] & ~btn_q[2];
   assign stop_evt  = btn_prev_q[1] & ~btn_q[1];
   assign clear_evt = btn_prev_q[0] & ~btn_q[0];
   assign key_evt   = (key_prev_q == '0) && ($countones(key_q) == 1);

   assign start_ok = start_evt & door_closed & ~timer_zero;

   // The prescaler only advances on cycles where COOK is kept.
   assign pre_en  = (state_q == COOK) & door_closed & ~stop_evt & ~timer_zero & ~clear_evt;
   assign pre_clr = clear_evt | ((state_q == IDLE) & ~stop_evt & start_ok);

   mw_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clock  (clock),
      .resetn (resetn),
      .clr    (pre_clr),
      .en     (pre_en),
      .tick   (tick)
   );

   // Door gate is combinational so the magnetron drops the cycle the door opens.
   assign mag_on = (state_q == COOK) & door_closed;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= IDLE;
         btn_q       <= '1;
         btn_prev_q  <= '1;
         key_q       <= '0;
         key_prev_q  <= '0;
         digit_cnt_q <= '0;
         shift_en    <= 1'b0;
         shift_digit <= '0;
         count_en    <= 1'b0;
         timer_clr   <= 1'b0;
         done        <= 1'b0;
      end else begin
         btn_q      <= {startn, stopn, clearn};
         btn_prev_q <= btn_q;
         key_q      <= keypad;
         key_prev_q <= key_q;
         shift_en   <= 1'b0;
         count_en   <= 1'b0;
         timer_clr  <= 1'b0;
         done       <= 1'b0;

         if (clear_evt) begin
            state_q     <= IDLE;
            timer_clr   <= 1'b1;
            digit_cnt_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (!stop_evt) begin
                     if (start_ok) begin
                        state_q <= COOK;
                     end else if (key_evt && (digit_cnt_q < DIGIT_MAX)) begin
                        shift_en    <= 1'b1;
                        shift_digit <= onehot_to_digit(key_q);
                        digit_cnt_q <= digit_cnt_q + DW'(1);
                     end
                  end
               end
               COOK: begin
                  if (!door_closed || stop_evt) begin
                     state_q <= PAUSE;
                  end else if (timer_zero) begin
                     state_q     <= IDLE;
                     done        <= 1'b1;
                     digit_cnt_q <= '0;
                  end else begin
                     count_en <= tick;
                  end
               end
               PAUSE: begin
                  if (stop_evt) begin
                     state_q     <= IDLE;
                     timer_clr   <= 1'b1;
                     digit_cnt_q <= '0;
                  end else if (start_ok) begin
                     state_q <= COOK;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule
